acc_reg_file_ctx: RTL and testbench
===================================

# acc_reg_file_ctx

Parametrised accumulator-centred register file for the 8-bit accumulator datapath: register 0 is the accumulator, with two independent combinational read ports, one indexed write port plus a dedicated accumulator write, and optional same-cycle write bypass. A shadow bank and a save/restore sequencer snapshot the whole file and restore it, one entry per cycle, for subroutine/interrupt context switches.

## Interface
- W, 8, data width in bits
- D, 4, index width; depth is 2**D entries, entry 0 is the accumulator
- BYPASS, 1, 1 = read ports return writeValue when reading an entry written in the same cycle; 0 = reads return stored contents only
- CLK  input  1  clock; all state updates on the rising edge
- Reset  input  1  synchronous, active-high reset
- RegWrite  input  1  write writeValue to registers[wr_index]
- AccWrite  input  1  write writeValue to registers[0]
- wr_index  input  D  write index
- writeValue  input  W  write data
- rd_index_a  input  D  read port A index
- rd_index_b  input  D  read port B index
- save_req  input  1  start copy main bank -> shadow bank
- restore_req  input  1  start copy shadow bank -> main bank
- Acc_out  output  W  registers[0], combinational
- Acc_zero  output  1  1 when Acc_out == 0
- Reg_out_a  output  W  port A read data, combinational
- Reg_out_b  output  W  port B read data, combinational
- busy  output  1  sequencer copying; normal writes ignored
- done  output  1  one-cycle pulse: copy complete
- reg_debug  output  W x 2**D  main bank contents, debug only

## Operation
- Reset: all main and shadow entries 0, FSM IDLE, counter 0, busy 0, done 0; therefore Acc_out 0, Acc_zero 1, Reg_out_a/b 0. Reset aborts any save/restore in progress; a partially written bank is cleared anyway.
- Write rules (IDLE only):
  - AccWrite only: registers[0] <= writeValue.
  - RegWrite only: registers[wr_index] <= writeValue (wr_index 0 writes the accumulator).
  - Both, wr_index != 0: both writes occur, same value, to registers[0] and registers[wr_index].
  - Both, wr_index == 0: single write of writeValue to registers[0].
- Bypass (BYPASS=1, IDLE, a write enabled): a read port whose index matches an entry being written this cycle (wr_index if RegWrite, 0 if AccWrite) outputs writeValue; Acc_out likewise when AccWrite or RegWrite with wr_index 0. BYPASS=0: no forwarding. Acc_zero follows Acc_out.
- FSM states: IDLE, SAVE, RESTORE.
  - IDLE -> SAVE on save_req; IDLE -> RESTORE on restore_req; both high: SAVE wins, restore_req dropped.
  - SAVE: shadow[cnt] <= registers[cnt]; RESTORE: registers[cnt] <= shadow[cnt]; cnt increments by 1 each cycle.
  - When cnt == 2**D-1 the final copy occurs, cnt wraps to 0, state -> IDLE, done pulses.
  - save_req/restore_req while busy: ignored, not queued.
- While busy: RegWrite/AccWrite ignored (write lost), bypass disabled; reads return current main-bank contents, including entries already restored.

## Timing
- Reads: zero latency, combinational from index to data.
- Writes: visible on outputs in the cycle after the enabling edge (same cycle via bypass).
- Request sampled at edge E in IDLE: busy = 1 from after E through edge E+2**D; entry i copied at edge E+1+i; busy = 0 and done = 1 for exactly the one cycle after edge E+2**D. Total 2**D busy cycles per operation.
- Back-to-back: a request in the done cycle is accepted (state is IDLE).
- A RegWrite presented in the done cycle is performed normally.

## Test plan
- Reset then read: after Reset high one edge, Acc_out=0, Acc_zero=1, Reg_out_a/b=0 for all indices, busy=0, done=0.
- Write conflict: AccWrite=1, RegWrite=1, wr_index=5, writeValue=8'h3C -> next cycle registers[0]=registers[5]=8'h3C; repeat with wr_index=0, writeValue=8'hA1 -> registers[0]=8'hA1, others unchanged.
- Bypass: BYPASS=1, RegWrite, wr_index=7, writeValue=8'h55, rd_index_a=7 -> Reg_out_a=8'h55 in the same cycle; BYPASS=0 -> Reg_out_a shows old value until the next cycle.
- Save/restore: fill entry i with i+8'h10, save_req one cycle -> busy 16 cycles, done one cycle; overwrite all with 8'hFF; restore_req -> after done, entry i = i+8'h10; RegWrite during busy has no effect.
- Simultaneous request: save_req=restore_req=1 in IDLE -> SAVE performed (shadow updated, main unchanged).
- Reset mid-operation: Reset at 6th busy cycle of RESTORE -> next cycle busy=0, done=0, all entries and shadow 0; a fresh save_req then runs the full 16 cycles.

Source files
------------

// File: rtl/acc_reg_file_ctx.sv
// Accumulator-centred register file (entry 0 = accumulator) with a shadow bank and save/restore sequencer.
// Reads are combinational with optional write bypass. While busy, 2**D cycles copy one entry per cycle and writes are dropped.
module acc_reg_file_ctx #(
  parameter int W      = 8,
  parameter int D      = 4,
  parameter bit BYPASS = 1'b1
) (
  input  logic                      CLK,
  input  logic                      Reset,
  input  logic                      RegWrite,
  input  logic                      AccWrite,
  input  logic [D-1:0]              wr_index,
  input  logic [W-1:0]              writeValue,
  input  logic [D-1:0]              rd_index_a,
  input  logic [D-1:0]              rd_index_b,
  input  logic                      save_req,
  input  logic                      restore_req,
  output logic [W-1:0]              Acc_out,
  output logic                      Acc_zero,
  output logic [W-1:0]              Reg_out_a,
  output logic [W-1:0]              Reg_out_b,
  output logic                      busy,
  output logic                      done,
  output logic [(2**D)-1:0][W-1:0]  reg_debug
);
  localparam int N = 2**D;
  localparam logic [D-1:0] LAST = D'(N - 1);

  typedef enum logic [1:0] {IDLE, SAVE, RESTORE} state_t;

  state_t         state, state_nxt;
  logic [D-1:0]   cnt;
  logic [W-1:0]   regs   [N];
  logic [W-1:0]   shadow [N];
  logic           idle;
  logic           fwd_en;
  logic           hit_a, hit_b, hit_acc;

  assign idle   = (state == IDLE);
  assign busy   = ~idle;
  assign fwd_en = BYPASS && idle;

  // A read matches the in-flight write if it targets wr_index (RegWrite) or entry 0 (AccWrite).
  assign hit_a   = fwd_en && ((RegWrite && (wr_index == rd_index_a)) ||
                              (AccWrite && (rd_index_a == '0)));
  assign hit_b   = fwd_en && ((RegWrite && (wr_index == rd_index_b)) ||
                              (AccWrite && (rd_index_b == '0)));
  assign hit_acc = fwd_en && (AccWrite || (RegWrite && (wr_index == '0)));

  assign Reg_out_a = hit_a   ? writeValue : regs[rd_index_a];
  assign Reg_out_b = hit_b   ? writeValue : regs[rd_index_b];
  assign Acc_out   = hit_acc ? writeValue : regs[0];
  assign Acc_zero  = (Acc_out == '0);

  always_comb begin
    for (int i = 0; i < N; i++) reg_debug[i] = regs[i];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (save_req)         state_nxt = SAVE;
        else if (restore_req) state_nxt = RESTORE;
      end
      default: begin
        if (cnt == LAST) state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      for (int i = 0; i < N; i++) begin
        regs[i]   <= '0;
        shadow[i] <= '0;
      end
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= !idle && (cnt == LAST);
      case (state)
        IDLE: begin
          // Both enables with wr_index 0 collapse to one write of the same value.
          if (AccWrite) regs[0]        <= writeValue;
          if (RegWrite) regs[wr_index] <= writeValue;
        end
        SAVE: begin
          shadow[cnt] <= regs[cnt];
          cnt         <= cnt + 1'b1;
        end
        RESTORE: begin
          regs[cnt] <= shadow[cnt];
          cnt       <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_reg_file_ctx.sv
// Randomised and directed bench for acc_reg_file_ctx; two instances (bypass on/off) share stimulus.
module tb_acc_reg_file_ctx;
  localparam int W = 8;
  localparam int D = 4;
  localparam int N = 16;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic           Reset, RegWrite, AccWrite, save_req, restore_req;
  logic [D-1:0]   wr_index, rd_index_a, rd_index_b;
  logic [W-1:0]   writeValue;

  logic [W-1:0]          acc_b1, ra_b1, rb_b1, acc_b0, ra_b0, rb_b0;
  logic                  accz_b1, busy_b1, done_b1, accz_b0, busy_b0, done_b0;
  logic [N-1:0][W-1:0]   dbg_b1, dbg_b0;

  acc_reg_file_ctx #(.W(W), .D(D), .BYPASS(1'b1)) u_byp (
    .CLK(CLK), .Reset(Reset), .RegWrite(RegWrite), .AccWrite(AccWrite),
    .wr_index(wr_index), .writeValue(writeValue),
    .rd_index_a(rd_index_a), .rd_index_b(rd_index_b),
    .save_req(save_req), .restore_req(restore_req),
    .Acc_out(acc_b1), .Acc_zero(accz_b1), .Reg_out_a(ra_b1), .Reg_out_b(rb_b1),
    .busy(busy_b1), .done(done_b1), .reg_debug(dbg_b1)
  );

  acc_reg_file_ctx #(.W(W), .D(D), .BYPASS(1'b0)) u_nob (
    .CLK(CLK), .Reset(Reset), .RegWrite(RegWrite), .AccWrite(AccWrite),
    .wr_index(wr_index), .writeValue(writeValue),
    .rd_index_a(rd_index_a), .rd_index_b(rd_index_b),
    .save_req(save_req), .restore_req(restore_req),
    .Acc_out(acc_b0), .Acc_zero(accz_b0), .Reg_out_a(ra_b0), .Reg_out_b(rb_b0),
    .busy(busy_b0), .done(done_b0), .reg_debug(dbg_b0)
  );

  // Reference model: banks as arrays, the copy as an operation plus a progress index.
  logic [W-1:0] mm [N];
  logic [W-1:0] ms [N];
  int           mop;      // 0 none, 1 save in progress, 2 restore in progress
  int           mk;       // next entry to copy
  logic         mdone;
  bit           model_ok = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_rd(input logic [D-1:0] idx, input bit byp);
    if (byp && mop == 0 &&
        ((RegWrite && wr_index == idx) || (AccWrite && idx == 0)))
      return writeValue;
    return mm[idx];
  endfunction

  task automatic model_edge();
    if (Reset) begin
      for (int i = 0; i < N; i++) begin mm[i] = '0; ms[i] = '0; end
      mop = 0; mk = 0; mdone = 1'b0; model_ok = 1'b1;
    end else begin
      mdone = 1'b0;
      if (mop == 0) begin
        if (AccWrite) mm[0] = writeValue;
        if (RegWrite) mm[wr_index] = writeValue;
        if (save_req)         begin mop = 1; mk = 0; end
        else if (restore_req) begin mop = 2; mk = 0; end
      end else begin
        if (mop == 1) ms[mk] = mm[mk];
        else          mm[mk] = ms[mk];
        if (mk == N - 1) begin mop = 0; mdone = 1'b1; end
        else mk++;
      end
    end
  endtask

  // Check all outputs against the model, then advance one clock.
  task automatic cyc();
    logic [N-1:0][W-1:0] e;
    #1;
    if (model_ok) begin
      for (int i = 0; i < N; i++) e[i] = mm[i];
      chk("acc_byp",  acc_b1,  exp_rd('0, 1'b1));
      chk("acc_nob",  acc_b0,  exp_rd('0, 1'b0));
      chk("zero_byp", accz_b1, exp_rd('0, 1'b1) == '0);
      chk("zero_nob", accz_b0, exp_rd('0, 1'b0) == '0);
      chk("rda_byp",  ra_b1,   exp_rd(rd_index_a, 1'b1));
      chk("rdb_byp",  rb_b1,   exp_rd(rd_index_b, 1'b1));
      chk("rda_nob",  ra_b0,   exp_rd(rd_index_a, 1'b0));
      chk("rdb_nob",  rb_b0,   exp_rd(rd_index_b, 1'b0));
      chk("busy_byp", busy_b1, mop != 0);
      chk("busy_nob", busy_b0, mop != 0);
      chk("done_byp", done_b1, mdone);
      chk("done_nob", done_b0, mdone);
      chk("dbg_byp",  dbg_b1,  e);
      chk("dbg_nob",  dbg_b0,  e);
    end
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
  endtask

  task automatic set_idle();
    RegWrite = 1'b0; AccWrite = 1'b0; save_req = 1'b0; restore_req = 1'b0;
    wr_index = '0; writeValue = '0;
  endtask

  task automatic rand_writes();
    RegWrite   = 1'($urandom_range(0, 1));
    AccWrite   = 1'($urandom_range(0, 1));
    wr_index   = D'($urandom_range(0, N - 1));
    writeValue = W'($urandom);
    rd_index_a = D'($urandom_range(0, N - 1));
    rd_index_b = D'($urandom_range(0, N - 1));
  endtask

  // Request already applied by caller; runs the busy window and checks its length and the done pulse.
  task automatic run_copy(input string tag);
    int bc;
    bc = 0;
    cyc();
    save_req = 1'b0; restore_req = 1'b0;
    for (int k = 0; k < N; k++) begin
      rand_writes();
      #1 bc += int'(busy_b1);
      cyc();
    end
    set_idle();
    #1;
    chk({tag, "_busy_cycles"}, bc, N);
    chk({tag, "_done"}, done_b1, 1'b1);
    chk({tag, "_idle"}, busy_b1, 1'b0);
    cyc();
    chk({tag, "_done_once"}, done_b1, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    Reset = 1'b1; set_idle(); rd_index_a = '0; rd_index_b = '0;
    @(negedge CLK);
    cyc();
    Reset = 1'b0;

    // Reset state over every index
    #1;
    chk("rst_acc", acc_b1, 8'h00);
    chk("rst_zero", accz_b1, 1'b1);
    chk("rst_busy", busy_b1, 1'b0);
    chk("rst_done", done_b1, 1'b0);
    for (int i = 0; i < N; i++) begin
      rd_index_a = D'(i); rd_index_b = D'(N - 1 - i);
      cyc();
    end

    // Dual write to accumulator and entry 5
    RegWrite = 1'b1; AccWrite = 1'b1; wr_index = 4'd5; writeValue = 8'h3C;
    cyc();
    set_idle(); rd_index_a = 4'd0; rd_index_b = 4'd5;
    #1;
    chk("conflict_acc", acc_b1, 8'h3C);
    chk("conflict_r5", rb_b1, 8'h3C);
    cyc();
    RegWrite = 1'b1; AccWrite = 1'b1; wr_index = 4'd0; writeValue = 8'hA1;
    cyc();
    set_idle();
    #1;
    chk("conflict0_acc", acc_b0, 8'hA1);
    chk("conflict0_r5", dbg_b0[5], 8'h3C);
    chk("conflict0_r1", dbg_b0[1], 8'h00);
    cyc();

    // Same-cycle forwarding
    RegWrite = 1'b1; wr_index = 4'd7; writeValue = 8'h55; rd_index_a = 4'd7;
    #1;
    chk("byp_on", ra_b1, 8'h55);
    chk("byp_off", ra_b0, 8'h00);
    cyc();
    set_idle();
    #1 chk("byp_off_next", ra_b0, 8'h55);
    cyc();

    // Save, clobber, restore
    for (int i = 0; i < N; i++) begin
      RegWrite = 1'b1; wr_index = D'(i); writeValue = W'(i + 8'h10);
      cyc();
    end
    set_idle();
    save_req = 1'b1;
    run_copy("save");
    for (int i = 0; i < N; i++) begin
      RegWrite = 1'b1; wr_index = D'(i); writeValue = 8'hFF;
      cyc();
    end
    set_idle();
    restore_req = 1'b1;
    cyc();
    restore_req = 1'b0;
    for (int k = 0; k < N; k++) begin
      rand_writes();
      cyc();
    end
    set_idle();
    #1;
    chk("restore_done", done_b1, 1'b1);
    for (int i = 0; i < N; i++) chk("restore_entry", dbg_b1[i], W'(i + 8'h10));
    cyc();

    // Simultaneous requests: save wins
    RegWrite = 1'b1; wr_index = 4'd3; writeValue = 8'h77;
    cyc();
    set_idle();
    save_req = 1'b1; restore_req = 1'b1;
    run_copy("both");
    chk("both_main", dbg_b1[3], 8'h77);
    RegWrite = 1'b1; wr_index = 4'd3; writeValue = 8'h00;
    cyc();
    set_idle();
    restore_req = 1'b1;
    run_copy("both_rest");
    chk("both_shadow", dbg_b1[3], 8'h77);

    // Reset during the sixth busy cycle of a restore
    restore_req = 1'b1;
    cyc();
    restore_req = 1'b0;
    for (int k = 0; k < 5; k++) cyc();
    #1 chk("mid_busy", busy_b1, 1'b1);
    Reset = 1'b1;
    cyc();
    Reset = 1'b0;
    #1;
    chk("mid_rst_busy", busy_b1, 1'b0);
    chk("mid_rst_done", done_b1, 1'b0);
    chk("mid_rst_main", dbg_b1, 128'h0);
    cyc();
    RegWrite = 1'b1; wr_index = 4'd4; writeValue = 8'h42;
    cyc();
    set_idle();
    restore_req = 1'b1;
    run_copy("post_rst_rest");
    chk("post_rst_shadow", dbg_b1[4], 8'h00);
    save_req = 1'b1;
    run_copy("post_rst_save");

    // Random traffic
    for (int k = 0; k < 600; k++) begin
      rand_writes();
      save_req    = ($urandom_range(0, 19) == 0);
      restore_req = ($urandom_range(0, 19) == 0);
      Reset       = ($urandom_range(0, 149) == 0);
      cyc();
    end
    Reset = 1'b0; set_idle();
    cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
